// File: rtl/mdu_sequencer.sv
// =============================================================================
// Module      : mdu_sequencer
// Description : Radix-2 shift-add unsigned multiplier owning HI/LO, with core
//               stall generation for MULTU / MFHI / MFLO / HI-LO write hazards.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mdu_sequencer #(
  parameter int WIDE = 32,
  parameter int CW   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WIDE-1:0] a,
  input  logic [WIDE-1:0] b,
  input  logic            rd_hi,
  input  logic            rd_lo,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [WIDE-1:0] wd,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [WIDE-1:0] hi,
  output logic [WIDE-1:0] lo
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [WIDE-1:0]   r_mcand;
  logic [2*WIDE-1:0] r_acc;
  logic [WIDE-1:0]   r_hi;
  logic [WIDE-1:0]   r_lo;

  logic [WIDE:0]     w_sum;
  logic [2*WIDE-1:0] w_shift;
  logic              w_accept;

  // The sum's carry lands in bit 2*WIDE-1 after the shift, so no separate
  // carry flop is needed: the shifted-out top bit is always zero.
  assign w_sum    = {1'b0, r_acc[2*WIDE-1:WIDE]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_shift  = {w_sum, r_acc[WIDE-1:1]};
  assign w_accept = start & (r_state != c_st_run);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        c_st_run: begin
          r_acc <= w_shift;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_hi    <= w_shift[2*WIDE-1:WIDE];
            r_lo    <= w_shift[WIDE-1:0];
            r_state <= c_st_done;
          end
        end
        default: begin
          // Start has priority over direct writes in IDLE/DONE.
          if (w_accept) begin
            r_mcand <= a;
            r_acc   <= {{WIDE{1'b0}}, b};
            r_cnt   <= CW'(WIDE);
            r_state <= c_st_run;
          end else begin
            r_state <= c_st_idle;
            if (wr_hi) r_hi <= wd;
            if (wr_lo) r_lo <= wd;
          end
        end
      endcase
    end
  end

  assign busy  = (r_state == c_st_run);
  assign done  = (r_state == c_st_done);
  assign stall = busy & (start | rd_hi | rd_lo | wr_hi | wr_lo);
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

`default_nettype wire
